header_inserter: RTL and testbench

//  Prepends a HEADER_SIZE-bit header to each Avalon-ST packet: header in via valid/ready, payload in on data_in.

---
 rtl/header_pkg.sv | 10 +
 rtl/avalon_st_if.sv | 13 +
 rtl/header_inserter.sv | 93 +++++++++
 tb/tb_header_inserter.sv | 384 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/header_pkg.sv
// rtl/header_pkg.sv - shared types and helpers for the header inserter/remover pair
package header_pkg;

  typedef enum logic [1:0] {HI_IDLE, HI_HDR, HI_PAYLOAD} hdr_ins_state_e;

  function automatic int num_hdr_beats(input int header_size, input int data_width);
    return (data_width > 0) ? (header_size / data_width) : 0;
  endfunction

endpackage

// File: rtl/avalon_st_if.sv
// rtl/avalon_st_if.sv - Avalon-ST style stream bundle with source/sink views
interface avalon_st_if #(
  parameter int DATA_WIDTH = 16
) ();
  logic [DATA_WIDTH-1:0] data;
  logic                  valid;
  logic                  ready;
  logic                  sop;
  logic                  eop;

  modport master (output data, output valid, output sop, output eop, input ready);
  modport slave  (input data, input valid, input sop, input eop, output ready);
endinterface

// File: rtl/header_inserter.sv
// rtl/header_inserter.sv - prepends a multi-beat header (MSB first) to each stream packet
module header_inserter
  import header_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int HEADER_SIZE = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [HEADER_SIZE-1:0] header_data,
  input  logic                   header_valid,
  output logic                   header_ready,
  avalon_st_if.slave             data_in,
  avalon_st_if.master            data_out
);

  localparam int NUM_BEATS = num_hdr_beats(HEADER_SIZE, DATA_WIDTH);
  localparam int CNT_W     = $clog2(NUM_BEATS) + 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NUM_BEATS - 1);

  if (HEADER_SIZE == 0 || (HEADER_SIZE % DATA_WIDTH) != 0) begin : g_bad_cfg
    $error("header_inserter: HEADER_SIZE must be a nonzero multiple of DATA_WIDTH");
  end

  hdr_ins_state_e         state_q, state_d;
  logic [HEADER_SIZE-1:0] hdr_sreg_q, hdr_sreg_d;
  logic [CNT_W-1:0]       beat_cnt_q, beat_cnt_d;

  // Input sop carries no meaning here: the header beat owns the packet start.
  logic sop_in_unused;
  assign sop_in_unused = data_in.sop;

  always_comb begin
    state_d       = state_q;
    hdr_sreg_d    = hdr_sreg_q;
    beat_cnt_d    = beat_cnt_q;
    header_ready  = 1'b0;
    data_in.ready = 1'b0;
    data_out.valid = 1'b0;
    data_out.data  = '0;
    data_out.sop   = 1'b0;
    data_out.eop   = 1'b0;

    case (state_q)
      HI_IDLE: begin
        header_ready = 1'b1;
        if (header_valid) begin
          hdr_sreg_d = header_data;
          beat_cnt_d = '0;
          state_d    = HI_HDR;
        end
      end

      HI_HDR: begin
        data_out.valid = 1'b1;
        data_out.data  = hdr_sreg_q[HEADER_SIZE-1 -: DATA_WIDTH];
        data_out.sop   = (beat_cnt_q == '0);
        if (data_out.ready) begin
          hdr_sreg_d = hdr_sreg_q << DATA_WIDTH;
          beat_cnt_d = beat_cnt_q + CNT_W'(1);
          if (beat_cnt_q == LAST_BEAT) begin
            state_d = HI_PAYLOAD;
          end
        end
      end

      HI_PAYLOAD: begin
        data_out.valid = data_in.valid;
        data_out.data  = data_in.data;
        data_out.eop   = data_in.eop;
        data_in.ready  = data_out.ready;
        if (data_in.valid && data_out.ready && data_in.eop) begin
          state_d = HI_IDLE;
        end
      end

      default: state_d = HI_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= HI_IDLE;
      hdr_sreg_q <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      hdr_sreg_q <= hdr_sreg_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

endmodule

// File: tb/tb_header_inserter.sv
// tb/tb_header_inserter.sv - randomized self-checking bench for header_inserter (16/16 and 8/16 configs)
module tb_header_inserter;

  typedef struct {
    logic [15:0] data;
    logic        sop;
    logic        eop;
    bit          hdr;
    int          k;
  } exp_t;

  typedef struct {
    logic [15:0] data;
    logic        sop;
    logic        eop;
    int          k;
    int          cyc;
  } log_t;

  typedef struct {
    logic [15:0] data;
    logic        sop;
    logic        eop;
  } pay_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   done;

  logic [15:0] hdr_data [2];
  logic        hdr_valid[2];
  logic [15:0] in_data  [2];
  logic        in_valid [2];
  logic        in_sop   [2];
  logic        in_eop   [2];
  logic        out_ready[2];

  logic        hdr_ready_w[2];
  logic        in_ready_w [2];
  logic [15:0] out_data_w [2];
  logic        out_valid_w[2];
  logic        out_sop_w  [2];
  logic        out_eop_w  [2];

  exp_t        exp_q[$];
  log_t        log_q[$];
  pay_t        pay_q[$];
  logic [15:0] hdr_list[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  avalon_st_if #(.DATA_WIDTH(16)) in16 ();
  avalon_st_if #(.DATA_WIDTH(16)) out16 ();
  avalon_st_if #(.DATA_WIDTH(8))  in8 ();
  avalon_st_if #(.DATA_WIDTH(8))  out8 ();

  assign in16.data     = in_data[0];
  assign in16.valid    = in_valid[0];
  assign in16.sop      = in_sop[0];
  assign in16.eop      = in_eop[0];
  assign out16.ready   = out_ready[0];
  assign in_ready_w[0] = in16.ready;
  assign out_data_w[0] = out16.data;
  assign out_valid_w[0] = out16.valid;
  assign out_sop_w[0]  = out16.sop;
  assign out_eop_w[0]  = out16.eop;

  assign in8.data      = in_data[1][7:0];
  assign in8.valid     = in_valid[1];
  assign in8.sop       = in_sop[1];
  assign in8.eop       = in_eop[1];
  assign out8.ready    = out_ready[1];
  assign in_ready_w[1] = in8.ready;
  assign out_data_w[1] = {8'h00, out8.data};
  assign out_valid_w[1] = out8.valid;
  assign out_sop_w[1]  = out8.sop;
  assign out_eop_w[1]  = out8.eop;

  header_inserter #(.DATA_WIDTH(16), .HEADER_SIZE(16)) u_dut16 (
    .clk          (clk),
    .rst          (rst),
    .header_data  (hdr_data[0]),
    .header_valid (hdr_valid[0]),
    .header_ready (hdr_ready_w[0]),
    .data_in      (in16),
    .data_out     (out16)
  );

  header_inserter #(.DATA_WIDTH(8), .HEADER_SIZE(16)) u_dut8 (
    .clk          (clk),
    .rst          (rst),
    .header_data  (hdr_data[1]),
    .header_valid (hdr_valid[1]),
    .header_ready (hdr_ready_w[1]),
    .data_in      (in8),
    .data_out     (out8)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  task automatic check_reset(input int k);
    chk("rst_header_ready", 32'(hdr_ready_w[k]), 32'd1);
    chk("rst_in_ready",     32'(in_ready_w[k]),  32'd0);
    chk("rst_out_valid",    32'(out_valid_w[k]), 32'd0);
    chk("rst_out_sop",      32'(out_sop_w[k]),   32'd0);
    chk("rst_out_eop",      32'(out_eop_w[k]),   32'd0);
    chk("rst_out_data",     32'(out_data_w[k]),  32'd0);
  endtask

  // Reference: output stream = header split MSB-first into beats, then payload with sop cleared.
  task automatic push_pkt(input int k, input logic [15:0] h, input int len, input bit rnd);
    logic [15:0] mask;
    logic [15:0] d;
    exp_t e;
    mask = (k == 0) ? 16'hFFFF : 16'h00FF;
    hdr_list.push_back(h);
    if (k == 0) begin
      e = '{data: h, sop: 1'b1, eop: 1'b0, hdr: 1'b1, k: k};
      exp_q.push_back(e);
    end else begin
      e = '{data: {8'h00, h[15:8]}, sop: 1'b1, eop: 1'b0, hdr: 1'b1, k: k};
      exp_q.push_back(e);
      e = '{data: {8'h00, h[7:0]}, sop: 1'b0, eop: 1'b0, hdr: 1'b1, k: k};
      exp_q.push_back(e);
    end
    for (int i = 0; i < len; i++) begin
      d = rnd ? (16'($urandom) & mask) : (16'(i) & mask);
      pay_q.push_back('{data: d,
                        sop: rnd ? 1'($urandom_range(0, 1)) : (i == 0),
                        eop: (i == len - 1)});
      e = '{data: d, sop: 1'b0, eop: (i == len - 1), hdr: 1'b0, k: k};
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_hs(input int k, input bit is_pay);
    bit acc;
    int n;
    n = 0;
    do begin
      #1;
      acc = is_pay ? (in_valid[k] && in_ready_w[k]) : (hdr_valid[k] && hdr_ready_w[k]);
      @(negedge clk);
      n++;
    end while (!acc && n < 3000);
    if (!acc) chk(is_pay ? "payload_handshake_timeout" : "header_handshake_timeout", 32'd0, 32'd1);
  endtask

  task automatic run(input int k, input int rmode, input bit gaps);
    done = 1'b0;
    out_ready[k] = 1'b1;
    fork
      begin
        while (!done) begin
          @(negedge clk);
          case (rmode)
            0:       out_ready[k] = 1'b1;
            1:       out_ready[k] = ~out_ready[k];
            default: out_ready[k] = ($urandom_range(0, 3) != 0);
          endcase
        end
        out_ready[k] = 1'b1;
      end
      begin
        fork
          begin
            while (hdr_list.size() > 0) begin
              if (gaps) begin
                hdr_valid[k] = 1'b0;
                repeat ($urandom_range(0, 2)) @(negedge clk);
              end
              hdr_data[k]  = hdr_list.pop_front();
              hdr_valid[k] = 1'b1;
              wait_hs(k, 1'b0);
            end
            hdr_valid[k] = 1'b0;
          end
          begin
            pay_t p;
            while (pay_q.size() > 0) begin
              if (gaps) begin
                in_valid[k] = 1'b0;
                repeat ($urandom_range(0, 2)) @(negedge clk);
              end
              p = pay_q.pop_front();
              in_data[k]  = p.data;
              in_sop[k]   = p.sop;
              in_eop[k]   = p.eop;
              in_valid[k] = 1'b1;
              wait_hs(k, 1'b1);
            end
            in_valid[k] = 1'b0;
          end
        join
        begin
          int n;
          n = 0;
          while (exp_q.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
          end
        end
        chk("drain_expected_left", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        done = 1'b1;
      end
    join
  endtask

  // Cycle-by-cycle protocol checker and scoreboard.
  bit          busy      [2];
  bit          prev_hs   [2];
  bit          prev_eop  [2];
  bit          prev_stall[2];
  logic [15:0] prev_data [2];
  logic        prev_sop  [2];
  logic        prev_eopb [2];

  always begin
    @(negedge clk);
    #2;
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        busy[k] = 0; prev_hs[k] = 0; prev_eop[k] = 0; prev_stall[k] = 0;
        continue;
      end
      if (prev_hs[k]) begin
        chk("hdr_latency_valid", 32'(out_valid_w[k]), 32'd1);
        chk("hdr_latency_sop",   32'(out_sop_w[k]),   32'd1);
      end
      if (prev_eop[k]) begin
        chk("idle_bubble_valid", 32'(out_valid_w[k]), 32'd0);
        chk("idle_bubble_ready", 32'(hdr_ready_w[k]), 32'd1);
      end
      if (prev_stall[k]) begin
        chk("stall_valid", 32'(out_valid_w[k]), 32'd1);
        chk("stall_data",  32'(out_data_w[k]),  32'(prev_data[k]));
        chk("stall_sop",   32'(out_sop_w[k]),   32'(prev_sop[k]));
        chk("stall_eop",   32'(out_eop_w[k]),   32'(prev_eopb[k]));
      end
      chk("header_ready_vs_busy", 32'(hdr_ready_w[k]), 32'(!busy[k]));
      if (out_valid_w[k] && out_ready[k]) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", 32'(out_data_w[k]), 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("beat_instance", 32'(k), 32'(e.k));
          chk("beat_data", 32'(out_data_w[k]), 32'(e.data));
          chk("beat_sop",  32'(out_sop_w[k]),  32'(e.sop));
          chk("beat_eop",  32'(out_eop_w[k]),  32'(e.eop));
          if (e.hdr) chk("in_ready_during_header", 32'(in_ready_w[k]), 32'd0);
        end
        log_q.push_back('{data: out_data_w[k], sop: out_sop_w[k], eop: out_eop_w[k], k: k, cyc: cyc});
      end
      prev_hs[k]    = hdr_valid[k] && hdr_ready_w[k];
      prev_eop[k]   = out_valid_w[k] && out_ready[k] && out_eop_w[k];
      prev_stall[k] = out_valid_w[k] && !out_ready[k];
      prev_data[k]  = out_data_w[k];
      prev_sop[k]   = out_sop_w[k];
      prev_eopb[k]  = out_eop_w[k];
      if (prev_hs[k])  busy[k] = 1;
      if (prev_eop[k]) busy[k] = 0;
    end
  end

  task automatic check_seq(input int k, input string tag);
    int nb;
    int total;
    nb = (k == 0) ? 1 : 2;
    total = nb + 10;
    chk({tag, "_beat_count"}, 32'(log_q.size()), 32'(total));
    if (log_q.size() == total) begin
      for (int i = 0; i < total; i++) begin
        logic [15:0] want;
        if (k == 0) want = (i == 0) ? 16'hABCD : 16'(i - 1);
        else        want = (i == 0) ? 16'h00AB : (i == 1) ? 16'h00CD : 16'(i - 2);
        chk({tag, "_data"}, 32'(log_q[i].data), 32'(want));
        chk({tag, "_sop"},  32'(log_q[i].sop),  32'(i == 0));
        chk({tag, "_eop"},  32'(log_q[i].eop),  32'(i == total - 1));
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      hdr_data[k] = '0; hdr_valid[k] = 0; in_data[k] = '0; in_valid[k] = 0;
      in_sop[k] = 0; in_eop[k] = 0; out_ready[k] = 1;
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #2;
    check_reset(0);
    check_reset(1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Basic passthrough with always-ready sink, both widths
    for (int k = 0; k < 2; k++) begin
      log_q.delete();
      push_pkt(k, 16'hABCD, 10, 1'b0);
      run(k, 0, 1'b0);
      check_seq(k, (k == 0) ? "t1" : "t2");
    end

    // Alternating backpressure must not change the sequence
    for (int k = 0; k < 2; k++) begin
      log_q.delete();
      push_pkt(k, 16'hABCD, 10, 1'b0);
      run(k, 1, 1'b0);
      check_seq(k, "t3");
    end

    // Back-to-back headers with header_valid held high
    log_q.delete();
    push_pkt(0, 16'h1111, 3, 1'b0);
    push_pkt(0, 16'h2222, 3, 1'b0);
    run(0, 0, 1'b0);
    chk("t4_beat_count", 32'(log_q.size()), 32'd8);
    if (log_q.size() == 8) begin
      chk("t4_second_hdr", 32'(log_q[4].data), 32'h2222);
      chk("t4_second_sop", 32'(log_q[4].sop),  32'd1);
      chk("t4_first_eop",  32'(log_q[3].eop),  32'd1);
      chk("t4_gap_cycles", 32'(log_q[4].cyc - log_q[3].cyc), 32'd2);
    end

    // Reset in the middle of a two-beat header
    log_q.delete();
    exp_q.push_back('{data: 16'h00AB, sop: 1'b1, eop: 1'b0, hdr: 1'b1, k: 1});
    out_ready[1] = 1'b1;
    hdr_data[1]  = 16'hABCD;
    hdr_valid[1] = 1'b1;
    wait_hs(1, 1'b0);
    hdr_valid[1] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #2;
    chk("t5_first_beat_seen", 32'(log_q.size()), 32'd1);
    check_reset(1);
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      #2;
      chk("t5_no_stale_valid", 32'(out_valid_w[1]), 32'd0);
    end
    @(negedge clk);
    log_q.delete();
    push_pkt(1, 16'hCDEF, 2, 1'b0);
    run(1, 0, 1'b0);
    chk("t5_count", 32'(log_q.size()), 32'd4);
    if (log_q.size() == 4) begin
      chk("t5_first_data", 32'(log_q[0].data), 32'h00CD);
      chk("t5_first_sop",  32'(log_q[0].sop),  32'd1);
      chk("t5_second_data", 32'(log_q[1].data), 32'h00EF);
    end

    // Randomized traffic: random headers, lengths, sop noise, gaps and backpressure
    for (int k = 0; k < 2; k++) begin
      for (int p = 0; p < 20; p++) begin
        push_pkt(k, 16'($urandom), $urandom_range(1, 6), 1'b1);
      end
      run(k, 2, 1'b1);
    end

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
